// File: rtl/lvds_link_tester_pkg.sv
// Shared definitions for the LVDS loopback self-test: FSM encoding,
// PRBS7 taps/seed and the error-counter format.
package lvds_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_ALIGN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // x^7 + x^6 + 1, Fibonacci form shifting left; feedback from bits 6 and 5
    localparam int         PRBS_W     = 7;
    localparam int         PRBS_TAP_A = 6;
    localparam int         PRBS_TAP_B = 5;
    localparam logic [6:0] PRBS_SEED  = 7'h7F;

    localparam int              ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_SAT = 16'hFFFF;

    localparam int WIN_W  = 11;
    localparam int HIST_W = 16;

    // Saturating increment for the error counter
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lvds_link_tester_prbs7_gen.sv
// PRBS7 source. Starts from the fixed seed at reset and steps once per
// advance pulse; bit_out is the MSB of the register.
module prbs7_gen
    import lvds_test_pkg::*;
(
    input  logic clk_in,
    input  logic reset_n,
    input  logic advance,
    output logic bit_out
);

    logic [PRBS_W-1:0] lfsr;

    // Shift left, feeding back the x^7/x^6 taps; a non-zero seed keeps it out of the lock-up state
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= PRBS_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[PRBS_W-2:0], lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B]};
        end
    end

    assign bit_out = lfsr[PRBS_W-1];

endmodule

// File: rtl/lvds_link_tester.sv
// LVDS loopback self-test: sends PRBS7 at clk_in/CLK_DIV, finds the loopback
// lag in whole bit periods, then counts bit errors over a fixed window.
module lvds_link_tester
    import lvds_test_pkg::*;
#(
    parameter int CLK_DIV    = 5,
    parameter int MAX_LAG    = 15,
    parameter int ALIGN_BITS = 32,
    parameter int TEST_BITS  = 1024
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              start,
    output logic              tx_bit,
    input  logic              rx_bit,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3:0]        lag,
    output logic [ERR_W-1:0]  err_count
);

    localparam int DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
    // Enough bits to fill the history up to MAX_LAG plus the synchronizer delay
    localparam int PRIME_BITS = MAX_LAG + 3;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic               active;
    logic               strobe;
    logic [1:0]         rx_sync;
    logic               rx_s;
    logic               prbs_bit;
    logic [HIST_W-1:1]  hist_q;
    logic [HIST_W-1:0]  hist;
    logic [WIN_W-1:0]   bit_cnt;
    logic [3:0]         lag_cand;
    logic               win_err;
    logic               mismatch;
    logic [ERR_W-1:0]   err_nxt;

    assign active   = (state == ST_PRIME) || (state == ST_ALIGN) || (state == ST_CHECK);
    assign strobe   = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rx_s     = rx_sync[1];
    assign tx_bit   = busy & prbs_bit;
    // hist[0] is always the bit on the wire right now
    assign hist     = {hist_q, tx_bit};
    assign mismatch = (rx_s != hist[lag_cand]);
    assign err_nxt  = mismatch ? sat_inc(err_count) : err_count;

    // Two-flop synchronizer; rx_bit comes straight from the pad
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) rx_sync <= 2'b00;
        else          rx_sync <= {rx_sync[0], rx_bit};
    end

    // Bit-period divider, parked at 0 whenever no test is running
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)     div_cnt <= '0;
        else if (!active) div_cnt <= '0;
        else if (strobe)  div_cnt <= '0;
        else              div_cnt <= div_cnt + 1'b1;
    end

    // Transmit history used to form the expected bit at each candidate lag
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)    hist_q <= '0;
        else if (strobe) hist_q <= hist[HIST_W-2:0];
    end

    prbs7_gen u_prbs (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .advance (strobe),
        .bit_out (prbs_bit)
    );

    // Test sequencer: prime, lag search, error count, report
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            lag       <= '0;
            err_count <= '0;
            bit_cnt   <= '0;
            lag_cand  <= '0;
            win_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_PRIME;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        lag       <= '0;
                        err_count <= '0;
                        bit_cnt   <= '0;
                        lag_cand  <= '0;
                        win_err   <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    if (strobe) begin
                        if (bit_cnt == WIN_W'(PRIME_BITS - 1)) begin
                            state   <= ST_ALIGN;
                            bit_cnt <= '0;
                            win_err <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (strobe) begin
                        if (bit_cnt == WIN_W'(ALIGN_BITS - 1)) begin
                            // Full window judged; the LFSR keeps running across restarts
                            bit_cnt <= '0;
                            win_err <= 1'b0;
                            if (!win_err && !mismatch) begin
                                state <= ST_CHECK;
                                lag   <= lag_cand;
                            end else if (lag_cand == 4'(MAX_LAG)) begin
                                state     <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                pass      <= 1'b0;
                                lag       <= 4'(MAX_LAG);
                                err_count <= ERR_SAT;
                            end else begin
                                lag_cand <= lag_cand + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            win_err <= win_err | mismatch;
                        end
                    end
                end
                ST_CHECK: begin
                    if (strobe) begin
                        err_count <= err_nxt;
                        if (bit_cnt == WIN_W'(TEST_BITS - 1)) begin
                            state   <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_nxt == '0);
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_link_tester.sv
// Directed bench for lvds_link_tester: loopback variants, lag search,
// align failure, error injection, ignored starts and mid-test reset.
module tb_lvds_link_tester;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_bit;
    logic        tx_bit;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  lag;
    logic [15:0] err_count;

    int checks = 0;
    int failures = 0;

    // 0: direct (optionally inverted), 1: 15-cycle delay, 2: stuck at 0
    int          mode = 0;
    logic        inv = 1'b0;
    logic [14:0] dl = '0;

    lvds_link_tester dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .start     (start),
        .tx_bit    (tx_bit),
        .rx_bit    (rx_bit),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .lag       (lag),
        .err_count (err_count)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) dl <= {dl[13:0], tx_bit};

    assign rx_bit = (mode == 1) ? dl[14] : (mode == 2) ? 1'b0 : (tx_bit ^ inv);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, run until done (bounded), optionally re-pulse start and
    // inject a 10-cycle inversion, then pulse start in the DONE cycle.
    task automatic run_test(input int restart_at, input int inv_at, input bit seed_chk,
                            output int lat);
        logic [6:0] first;
        int k;
        first = '0;
        lat = -1;
        k = 0;
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        while (k < 8000 && lat < 0) begin
            @(negedge clk_in);
            k++;
            start = (k == restart_at);
            if (inv_at >= 0) inv = (k >= inv_at) && (k < inv_at + 10);
            if (k < 35 && (k % 5) == 2) first[k / 5] = tx_bit;
            if (k == 50) chk("busy_mid", busy, 1);
            if (done) lat = k;
        end
        inv = 1'b0;
        if (seed_chk) chk("seed_bits", first, 7'h7F);
        // start during the DONE cycle must not launch a new test
        start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        chk("done_one_cycle", done, 0);
        @(negedge clk_in);
        chk("done_start_ignored", busy, 0);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_lag", lag, 0);
        chk("rst_err", err_count, 0);
        chk("rst_tx", tx_bit, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // direct loopback
        mode = 0;
        run_test(-1, -1, 1'b1, lat);
        chk("direct_lat", lat, 5370);
        chk("direct_lag", lag, 0);
        chk("direct_err", err_count, 0);
        chk("direct_pass", pass, 1);

        // 3-bit-period loopback delay
        mode = 1;
        run_test(-1, -1, 1'b0, lat);
        chk("lag3_lat", lat, 5850);
        chk("lag3_lag", lag, 3);
        chk("lag3_err", err_count, 0);
        chk("lag3_pass", pass, 1);

        // stuck receiver
        mode = 2;
        run_test(-1, -1, 1'b0, lat);
        chk("stuck_lat", lat, 2650);
        chk("stuck_lag", lag, 15);
        chk("stuck_err", err_count, 16'hFFFF);
        chk("stuck_pass", pass, 0);

        // two inverted bit periods during CHECK
        mode = 0;
        run_test(-1, 1000, 1'b0, lat);
        chk("inv_lat", lat, 5370);
        chk("inv_lag", lag, 0);
        chk("inv_err", err_count, 2);
        chk("inv_pass", pass, 0);

        // start re-pulsed mid-test
        run_test(100, -1, 1'b0, lat);
        chk("restart_lat", lat, 5370);
        chk("restart_pass", pass, 1);
        chk("restart_err", err_count, 0);

        // reset mid-CHECK after injecting two errors
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        for (int k = 1; k < 1000; k++) begin
            @(negedge clk_in);
            inv = (k >= 500) && (k < 510);
        end
        inv = 1'b0;
        chk("pre_rst_err", err_count, 2);
        chk("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_tx", tx_bit, 0);
        chk("midrst_err", err_count, 0);
        @(negedge clk_in);
        reset_n = 1'b1;
        begin
            int ndone;
            ndone = 0;
            for (int k = 0; k < 6000; k++) begin
                @(negedge clk_in);
                if (done) ndone++;
            end
            chk("midrst_no_done", ndone, 0);
        end
        run_test(-1, -1, 1'b1, lat);
        chk("after_rst_lat", lat, 5370);
        chk("after_rst_pass", pass, 1);
        chk("after_rst_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
